// File: rtl/port_drain_arbiter.sv
// Round-robin drain of four switch output ports into one backpressured byte stream,
// with a one-cycle length/overflow summary at the end of each packet.
//   state | meaning
//   IDLE  | search ports starting at rr for one presenting ready
//   READ  | drain the granted port while it stays ready
//   DONE  | report packet summary, advance rr past the grant
//   GAP   | idle spacing before the next search
module port_drain_arbiter #(
  parameter int MAX_LEN    = 64,
  parameter int GAP_CYCLES = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] data_0,
  input  logic [7:0] data_1,
  input  logic [7:0] data_2,
  input  logic [7:0] data_3,
  input  logic       ready_0,
  input  logic       ready_1,
  input  logic       ready_2,
  input  logic       ready_3,
  output logic       read_0,
  output logic       read_1,
  output logic       read_2,
  output logic       read_3,
  output logic [7:0] out_data,
  output logic [1:0] out_port,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       pkt_done,
  output logic [7:0] pkt_len,
  output logic       pkt_err
);

  typedef enum logic [1:0] {IDLE, READ, DONE, GAP} state_t;

  localparam logic [8:0] MAX_LEN_W = 9'(MAX_LEN);
  localparam logic [2:0] GAP_W     = 3'(GAP_CYCLES);

  state_t          state, state_nxt;
  logic [1:0]      rr, grant, hit_port, cand;
  logic            hit, read_g, drop_g;
  logic [7:0]      len_cnt;
  logic [2:0]      gap_cnt;
  logic [3:0]      ready_v, read_v;
  logic [3:0][7:0] data_v;

  assign ready_v = {ready_3, ready_2, ready_1, ready_0};
  assign data_v  = {data_3, data_2, data_1, data_0};

  always_comb begin
    hit      = 1'b0;
    hit_port = rr;
    cand     = rr;
    for (int i = 0; i < 4; i++) begin
      cand = rr + 2'(i);
      if (!hit && ready_v[cand]) begin
        hit      = 1'b1;
        hit_port = cand;
      end
    end
  end

  // A held output byte blocks the next read until downstream takes it.
  assign read_g = (state == READ) && ready_v[grant] && (!out_valid || out_ready);
  assign drop_g = (state == READ) && !ready_v[grant];
  assign read_v = read_g ? (4'b0001 << grant) : 4'b0000;

  assign read_0 = read_v[0];
  assign read_1 = read_v[1];
  assign read_2 = read_v[2];
  assign read_3 = read_v[3];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (hit) state_nxt = READ;
      READ: if (drop_g) state_nxt = DONE;
      DONE: state_nxt = (GAP_CYCLES == 0) ? IDLE : GAP;
      GAP:  if (gap_cnt <= 3'd1) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      grant     <= '0;
      rr        <= '0;
      len_cnt   <= '0;
      gap_cnt   <= '0;
      out_data  <= '0;
      out_port  <= '0;
      out_valid <= 1'b0;
      pkt_done  <= 1'b0;
      pkt_len   <= '0;
      pkt_err   <= 1'b0;
    end else begin
      pkt_done <= 1'b0;
      if (state == IDLE && hit) grant <= hit_port;

      if (read_g) begin
        out_data  <= data_v[grant];
        out_port  <= grant;
        out_valid <= 1'b1;
        if (len_cnt != 8'hff) len_cnt <= len_cnt + 8'd1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end

      // Summary registers load as the FSM enters DONE, so the pulse spans the DONE cycle.
      if (drop_g) begin
        pkt_done <= 1'b1;
        pkt_len  <= len_cnt;
        pkt_err  <= {1'b0, len_cnt} > MAX_LEN_W;
      end

      if (state == DONE) begin
        len_cnt <= '0;
        rr      <= grant + 2'd1;
        gap_cnt <= GAP_W;
      end else if (state == GAP) begin
        gap_cnt <= gap_cnt - 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_port_drain_arbiter.sv
// Scoreboard bench for port_drain_arbiter: port models feed packets, bytes and
// packet summaries are predicted in order and compared as the DUT produces them.
module tb_port_drain_arbiter;

  localparam int MAX_LEN    = 64;
  localparam int GAP_CYCLES = 1;

  typedef struct packed {
    logic [1:0] port;
    logic [7:0] len;
    logic       err;
  } pkt_t;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] data [4];
  logic [3:0] ready;
  logic [3:0] rd;
  logic [7:0] out_data;
  logic [1:0] out_port;
  logic       out_valid;
  logic       out_ready;
  logic       pkt_done;
  logic [7:0] pkt_len;
  logic       pkt_err;

  int         plen  [4][$];
  logic [7:0] pbase [4][$];
  int         rem   [4];
  logic [7:0] cur   [4];
  bit         cool  [4];

  pkt_t       pq[$];
  logic [9:0] bq[$];

  int         n_chk = 0;
  int         n_err = 0;
  int         slot = 0;
  int         nread = 0;
  int         last_done = -1;
  int         stall = 0;
  int         n0;
  bit         gap_chk = 1'b0;
  bit         in_pkt = 1'b0;
  logic [1:0] last_port = 2'd0;

  always #5 clock = ~clock;

  port_drain_arbiter #(.MAX_LEN(MAX_LEN), .GAP_CYCLES(GAP_CYCLES)) dut (
    .clock     (clock),
    .reset     (reset),
    .data_0    (data[0]),
    .data_1    (data[1]),
    .data_2    (data[2]),
    .data_3    (data[3]),
    .ready_0   (ready[0]),
    .ready_1   (ready[1]),
    .ready_2   (ready[2]),
    .ready_3   (ready[3]),
    .read_0    (rd[0]),
    .read_1    (rd[1]),
    .read_2    (rd[2]),
    .read_3    (rd[3]),
    .out_data  (out_data),
    .out_port  (out_port),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .pkt_done  (pkt_done),
    .pkt_len   (pkt_len),
    .pkt_err   (pkt_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic add_pkt(input int p, input int n, input logic [7:0] base);
    plen[p].push_back(n);
    pbase[p].push_back(base);
  endtask

  task automatic expect_pkt(input int p, input int n);
    pkt_t e;
    e.port = 2'(p);
    e.len  = 8'(n > 255 ? 255 : n);
    e.err  = (n > MAX_LEN);
    pq.push_back(e);
  endtask

  function automatic bit busy();
    for (int p = 0; p < 4; p++)
      if (rem[p] != 0 || plen[p].size() != 0) return 1'b1;
    return 1'b0;
  endfunction

  // One cycle: check registered outputs, drive inputs, then observe reads/transfers.
  task automatic step();
    pkt_t e;
    @(negedge clock);
    slot++;
    if (pkt_done) begin
      chk("pkt_pending", 32'(pq.size() != 0), 32'd1);
      if (pq.size() != 0) begin
        e = pq.pop_front();
        chk("pkt_len", 32'(pkt_len), 32'(e.len));
        chk("pkt_err", 32'(pkt_err), 32'(e.err));
        chk("pkt_port", 32'(last_port), 32'(e.port));
      end
      last_done = slot;
      in_pkt = 1'b0;
    end
    for (int p = 0; p < 4; p++) begin
      if (cool[p]) cool[p] = 1'b0;
      else if (rem[p] == 0 && plen[p].size() != 0) begin
        rem[p] = plen[p].pop_front();
        cur[p] = pbase[p].pop_front();
      end
      ready[p] = (rem[p] != 0);
      data[p]  = (rem[p] != 0) ? cur[p] : 8'($urandom);
    end
    out_ready = (stall == 0);
    if (stall > 0) stall--;
    #1;
    chk("read_onehot", 32'($countones(rd) <= 1), 32'd1);
    if (out_valid && out_ready) begin
      chk("out_pending", 32'(bq.size() != 0), 32'd1);
      if (bq.size() != 0) chk("out_byte", 32'({out_port, out_data}), 32'(bq.pop_front()));
    end else if (out_valid) begin
      chk("bp_read", 32'(rd), 32'd0);
      if (bq.size() != 0) chk("bp_hold", 32'({out_port, out_data}), 32'(bq[0]));
    end
    for (int p = 0; p < 4; p++) begin
      if (rd[p]) begin
        chk("read_ready", 32'(ready[p]), 32'd1);
        if (!in_pkt) begin
          in_pkt = 1'b1;
          if (gap_chk && last_done >= 0) chk("gap", 32'(slot - last_done), 32'(2 + GAP_CYCLES));
        end
        bq.push_back({2'(p), data[p]});
        last_port = 2'(p);
        nread++;
        if (rem[p] > 0) begin
          rem[p]--;
          cur[p] = cur[p] + 8'd1;
          if (rem[p] == 0) cool[p] = 1'b1;
        end
      end
    end
  endtask

  task automatic drain(input int budget);
    int i;
    i = 0;
    while (i < budget && (pq.size() != 0 || bq.size() != 0 || busy())) begin
      step();
      i++;
    end
    chk("drain", 32'(pq.size() + bq.size()), 32'd0);
    repeat (2 + GAP_CYCLES) step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    ready = 4'b0;
    out_ready = 1'b1;
    for (int p = 0; p < 4; p++) begin
      data[p] = 8'h00;
      rem[p]  = 0;
      cur[p]  = 8'h00;
      cool[p] = 1'b0;
    end
    reset = 1'b1;
    repeat (3) @(negedge clock);
    #1;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_port", 32'(out_port), 32'd0);
    chk("rst_done", 32'(pkt_done), 32'd0);
    chk("rst_len", 32'(pkt_len), 32'd0);
    chk("rst_err", 32'(pkt_err), 32'd0);
    chk("rst_read", 32'(rd), 32'd0);
    reset = 1'b0;

    // fairness: all ports ready, 3-byte packets, order 0,1,2,3,0
    gap_chk = 1'b1;
    last_done = -1;
    add_pkt(0, 3, 8'h00); add_pkt(0, 3, 8'h08);
    add_pkt(1, 3, 8'h20); add_pkt(2, 3, 8'h30); add_pkt(3, 3, 8'h40);
    expect_pkt(0, 3); expect_pkt(1, 3); expect_pkt(2, 3); expect_pkt(3, 3); expect_pkt(0, 3);
    drain(200);
    gap_chk = 1'b0;

    // single packet on port 2
    add_pkt(2, 5, 8'h10);
    expect_pkt(2, 5);
    drain(60);

    // backpressure: stall 3 cycles after the 2nd byte of a port 1 packet
    add_pkt(1, 4, 8'h50);
    expect_pkt(1, 4);
    n0 = nread;
    for (int i = 0; i < 20 && nread < n0 + 2; i++) step();
    chk("bp_start", 32'(nread - n0), 32'd2);
    stall = 3;
    drain(60);

    // overflow on port 3
    add_pkt(3, 70, 8'h80);
    expect_pkt(3, 70);
    drain(200);

    // rotation after port 3: 0 before 2, then after 2: 3 before 1
    add_pkt(0, 2, 8'hA0); add_pkt(2, 2, 8'hB0);
    expect_pkt(0, 2); expect_pkt(2, 2);
    drain(80);
    add_pkt(1, 2, 8'hC0); add_pkt(3, 2, 8'hD0);
    expect_pkt(3, 2); expect_pkt(1, 2);
    drain(80);

    // mid-packet reset on port 1
    add_pkt(1, 6, 8'hE0);
    n0 = nread;
    for (int i = 0; i < 20 && nread < n0 + 2; i++) step();
    chk("mr_start", 32'(nread - n0), 32'd2);
    reset = 1'b1;
    #1;
    chk("mr_read", 32'(rd), 32'd0);
    chk("mr_valid", 32'(out_valid), 32'd0);
    chk("mr_done", 32'(pkt_done), 32'd0);
    bq.delete();
    pq.delete();
    in_pkt = 1'b0;
    for (int p = 0; p < 4; p++) begin
      rem[p]  = 0;
      cool[p] = 1'b0;
      plen[p].delete();
      pbase[p].delete();
    end
    ready = 4'b0;
    @(negedge clock);
    #2 reset = 1'b0;
    repeat (4) step();
    add_pkt(0, 2, 8'hF0); add_pkt(2, 2, 8'h70);
    expect_pkt(0, 2); expect_pkt(2, 2);
    drain(80);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
